// File: rtl/lock_pkg.sv
// Shared types and constants for the combination lock and its code writer.
package lock_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;

    // Programming FSM states; encodings double as the status codes.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_CONFIRM = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTER   = 3'd1;
    localparam logic [2:0] ST_CONFIRM = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    // Active-low 7-segment patterns, bit 6 = segment g ... bit 0 = segment a.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Map an FSM state onto the externally visible status code.
    function automatic logic [2:0] status_of(input state_t s);
        logic [2:0] st;
        case (s)
            S_IDLE:    st = ST_IDLE;
            S_ENTER:   st = ST_ENTER;
            S_CONFIRM: st = ST_CONFIRM;
            S_DONE:    st = ST_DONE;
            S_ERROR:   st = ST_ERROR;
            default:   st = ST_ERROR;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/seg7_bcd.sv
// BCD digit to active-low 7-segment pattern; non-BCD values show blank.
module seg7_bcd (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    import lock_pkg::*;

    // Segment lookup for 0..9, blank for A..F.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lock_code_writer.sv
// Two-pass (entry + confirm) programmer for the lock's stored code.
// A matching confirm commits the code with a single-cycle write pulse.
module lock_code_writer #(
    parameter int                                NUM_DIGITS   = lock_pkg::NUM_DIGITS,
    parameter int                                DIGIT_W      = lock_pkg::DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = 24'h654321
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_start,
    input  logic                          abort,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          digit_valid,
    output logic [NUM_DIGITS*DIGIT_W-1:0] code_out,
    output logic                          code_wr,
    output logic [2:0]                    status,
    output logic [2:0]                    digit_cnt,
    output logic [6:0]                    hex0
);
    import lock_pkg::*;

    localparam int         CODE_W   = NUM_DIGITS * DIGIT_W;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CODE_W-1:0]   buf1_r;
    logic [CODE_W-1:0]   buf1_nxt_s;
    logic                mismatch_r;
    logic                mismatch_nxt_s;
    logic                mismatch_now_s;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_nxt_s;
    logic [CODE_W-1:0]   code_r;
    logic [CODE_W-1:0]   code_nxt_s;
    logic                wr_r;
    logic                wr_nxt_s;
    logic [6:0]          hex_r;
    logic [6:0]          hex_nxt_s;
    logic [2:0]          status_r;
    logic [6:0]          seg_s;
    logic                digit_ok_s;
    logic [DIGIT_W-1:0]  ref_digit_s;

    seg7_bcd u_seg (
        .bcd (digit_in),
        .seg (seg_s)
    );

    assign digit_ok_s  = (digit_in <= 4'd9);
    assign ref_digit_s = buf1_r[int'(cnt_r) * DIGIT_W +: DIGIT_W];

    // Next-state, buffer, counter and display decode with abort > prog_start > digit priority.
    always_comb begin
        state_nxt_s    = state_r;
        buf1_nxt_s     = buf1_r;
        mismatch_nxt_s = mismatch_r;
        mismatch_now_s = mismatch_r | (digit_in != ref_digit_s);
        cnt_nxt_s      = cnt_r;
        code_nxt_s     = code_r;
        wr_nxt_s       = 1'b0;
        hex_nxt_s      = hex_r;

        if (abort) begin
            state_nxt_s    = S_IDLE;
            buf1_nxt_s     = '0;
            mismatch_nxt_s = 1'b0;
            cnt_nxt_s      = 3'd0;
            hex_nxt_s      = SEG_BLANK;
        end else if (prog_start) begin
            state_nxt_s    = S_ENTER;
            buf1_nxt_s     = '0;
            mismatch_nxt_s = 1'b0;
            cnt_nxt_s      = 3'd0;
            hex_nxt_s      = SEG_BLANK;
        end else if (digit_valid) begin
            case (state_r)
                S_ENTER: begin
                    if (digit_ok_s) begin
                        buf1_nxt_s[int'(cnt_r) * DIGIT_W +: DIGIT_W] = digit_in;
                        hex_nxt_s = seg_s;
                        if (cnt_r == LAST_IDX) begin
                            state_nxt_s = S_CONFIRM;
                            cnt_nxt_s   = 3'd0;
                        end else begin
                            cnt_nxt_s = cnt_r + 3'd1;
                        end
                    end else begin
                        state_nxt_s = S_ERROR;
                        cnt_nxt_s   = 3'd0;
                        hex_nxt_s   = SEG_E;
                    end
                end
                S_CONFIRM: begin
                    if (digit_ok_s) begin
                        hex_nxt_s      = seg_s;
                        mismatch_nxt_s = mismatch_now_s;
                        if (cnt_r == LAST_IDX) begin
                            cnt_nxt_s = 3'd0;
                            if (mismatch_now_s) begin
                                state_nxt_s = S_ERROR;
                            end else begin
                                state_nxt_s = S_DONE;
                                code_nxt_s  = buf1_r;
                                wr_nxt_s    = 1'b1;
                            end
                        end else begin
                            cnt_nxt_s = cnt_r + 3'd1;
                        end
                    end else begin
                        state_nxt_s = S_ERROR;
                        cnt_nxt_s   = 3'd0;
                        hex_nxt_s   = SEG_E;
                    end
                end
                default: begin
                    state_nxt_s = state_r;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, datapath and registered outputs; status is decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            buf1_r     <= '0;
            mismatch_r <= 1'b0;
            cnt_r      <= 3'd0;
            code_r     <= DEFAULT_CODE;
            wr_r       <= 1'b0;
            hex_r      <= SEG_BLANK;
            status_r   <= ST_IDLE;
        end else begin
            state_r    <= state_nxt_s;
            buf1_r     <= buf1_nxt_s;
            mismatch_r <= mismatch_nxt_s;
            cnt_r      <= cnt_nxt_s;
            code_r     <= code_nxt_s;
            wr_r       <= wr_nxt_s;
            hex_r      <= hex_nxt_s;
            status_r   <= status_of(state_nxt_s);
        end
    end

    assign code_out  = code_r;
    assign code_wr   = wr_r;
    assign status    = status_r;
    assign digit_cnt = cnt_r;
    assign hex0      = hex_r;

endmodule

// File: tb/tb_lock_code_writer.sv
// Scoreboard bench for lock_code_writer: each driven cycle pushes the
// reference model's expected outputs, popped and compared after the edge.
module tb_lock_code_writer;

    logic        clk;
    logic        rst_n;
    logic        prog_start;
    logic        abort;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic [23:0] code_out;
    logic        code_wr;
    logic [2:0]  status;
    logic [2:0]  digit_cnt;
    logic [6:0]  hex0;

    typedef struct {
        logic [2:0]  st;
        logic [2:0]  cnt;
        logic [23:0] code;
        logic        wr;
        logic [6:0]  hex;
    } exp_t;

    exp_t sb_q[$];

    int err_cnt;
    int chk_cnt;

    // Reference model state
    int          m_state;
    int          m_cnt;
    logic [3:0]  m_buf [6];
    logic        m_mm;
    logic [23:0] m_code;
    logic        m_wr;
    logic [6:0]  m_hex;
    logic [6:0]  seg_tab [10];

    lock_code_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_start  (prog_start),
        .abort       (abort),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .code_out    (code_out),
        .code_wr     (code_wr),
        .status      (status),
        .digit_cnt   (digit_cnt),
        .hex0        (hex0)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        for (int i = 0; i < 6; i++) m_buf[i] = 4'd0;
        m_mm    = 1'b0;
        m_code  = 24'h654321;
        m_wr    = 1'b0;
        m_hex   = 7'h7F;
    endtask

    task automatic model_step(input logic ab, input logic ps, input logic dv, input logic [3:0] d);
        m_wr = 1'b0;
        if (ab) begin
            m_state = 0; m_cnt = 0; m_mm = 1'b0; m_hex = 7'h7F;
            for (int i = 0; i < 6; i++) m_buf[i] = 4'd0;
        end else if (ps) begin
            m_state = 1; m_cnt = 0; m_mm = 1'b0; m_hex = 7'h7F;
            for (int i = 0; i < 6; i++) m_buf[i] = 4'd0;
        end else if (dv && (m_state == 1 || m_state == 2)) begin
            if (d > 4'd9) begin
                m_state = 4; m_cnt = 0; m_hex = 7'b0000110;
            end else begin
                m_hex = seg_tab[d];
                if (m_state == 1) m_buf[m_cnt] = d;
                else if (m_buf[m_cnt] != d) m_mm = 1'b1;
                if (m_cnt < 5) begin
                    m_cnt++;
                end else begin
                    m_cnt = 0;
                    if (m_state == 1) begin
                        m_state = 2;
                    end else if (m_mm) begin
                        m_state = 4;
                    end else begin
                        m_state = 3;
                        for (int i = 0; i < 6; i++) m_code[4*i +: 4] = m_buf[i];
                        m_wr = 1'b1;
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, push expectation, compare after the edge.
    task automatic cyc(input logic ab, input logic ps, input logic dv, input logic [3:0] d);
        exp_t e;
        abort = ab; prog_start = ps; digit_valid = dv; digit_in = d;
        model_step(ab, ps, dv, d);
        e.st = 3'(m_state); e.cnt = 3'(m_cnt); e.code = m_code; e.wr = m_wr; e.hex = m_hex;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0; prog_start = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("status",    32'(status),    32'(e.st));
            chk("digit_cnt", 32'(digit_cnt), 32'(e.cnt));
            chk("code_out",  32'(code_out),  32'(e.code));
            chk("code_wr",   32'(code_wr),   32'(e.wr));
            chk("hex0",      32'(hex0),      32'(e.hex));
        end
    endtask

    task automatic enter6(input logic [23:0] seq);
        for (int i = 0; i < 6; i++) begin
            logic [3:0] dg;
            dg = seq[4*(5-i) +: 4];
            cyc(1'b0, 1'b0, 1'b1, dg);
        end
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_code"},   32'(code_out),  32'h654321);
        chk({tag, "_wr"},     32'(code_wr),   32'd0);
        chk({tag, "_status"}, 32'(status),    32'd0);
        chk({tag, "_cnt"},    32'(digit_cnt), 32'd0);
        chk({tag, "_hex"},    32'(hex0),      32'h7F);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wr_seen;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        err_cnt = 0; chk_cnt = 0;
        rst_n = 1'b1; prog_start = 1'b0; abort = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;

        // Asynchronous reset before any clock edge
        async_reset_check("rst");

        // Idle ignores digits
        cyc(1'b0, 1'b0, 1'b1, 4'd3);

        // Mismatching confirm: error only after the 6th confirm digit
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        enter6(24'h987654);
        chk("mm_in_confirm", 32'(status), 32'd2);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, (i == 3) ? 4'd0 : 4'(9 - i));
        chk("mm_not_early", 32'(status), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 4'd4);
        chk("mm_error", 32'(status), 32'd4);
        chk("mm_code_kept", 32'(code_out), 32'h654321);

        // Invalid digit mid-entry
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd1);
        cyc(1'b0, 1'b0, 1'b1, 4'd2);
        cyc(1'b0, 1'b0, 1'b1, 4'hB);
        chk("bad_status", 32'(status), 32'd4);
        chk("bad_hex", 32'(hex0), 32'h06);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        chk("bad_restart", 32'(status), 32'd1);

        // Abort with simultaneous digit during confirm
        enter6(24'h987654);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 4'(9 - i));
        cyc(1'b1, 1'b0, 1'b1, 4'd6);
        chk("abort_status", 32'(status), 32'd0);
        chk("abort_code", 32'(code_out), 32'h654321);
        cyc(1'b0, 1'b1, 1'b1, 4'd5);
        chk("ps_dv_cnt", 32'(digit_cnt), 32'd0);

        // Successful commit
        enter6(24'h987654);
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 4'(9 - i));
            if (code_wr) wr_seen++;
        end
        chk("ok_status", 32'(status), 32'd3);
        chk("ok_code", 32'(code_out), 32'h456789);
        chk("ok_hex", 32'(hex0), 32'h19);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 4'(i));
            if (code_wr) wr_seen++;
        end
        chk("wr_pulses", 32'(wr_seen), 32'd1);
        chk("done_code", 32'(code_out), 32'h456789);

        // Second program cycle
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        enter6(24'h111111);
        enter6(24'h111111);
        chk("second_code", 32'(code_out), 32'h111111);

        // Reset in the middle of entry
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd7);
        cyc(1'b0, 1'b0, 1'b1, 4'd8);
        async_reset_check("midrst");
        cyc(1'b0, 1'b0, 1'b1, 4'd2);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic ab, ps, dv;
            logic [3:0] d;
            ab = ($urandom_range(0, 29) == 0);
            ps = ($urandom_range(0, 19) == 0);
            dv = ($urandom_range(0, 2) != 0);
            d  = ($urandom_range(0, 15) == 0) ? 4'hC : 4'($urandom_range(0, 2));
            cyc(ab, ps, dv, d);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/lock_code_writer.md
Name: lock_code_writer

Overview:
- Programming-side companion to the combination lock: the lock reads and compares a stored 6-digit code; this block writes it.
- Operator enters a new 6-digit code twice (entry + confirm) on SW-style digit inputs, one digit per strobe.
- On a matching confirm it commits the code to the lock's code register via a one-cycle write pulse.
- Drives a status code and a 7-segment echo of the last accepted digit for the DE1-SoC HEX display.

Parameters:
NUM_DIGITS, 6, digits per combination
DIGIT_W, 4, bits per digit (BCD)
DEFAULT_CODE, 24'h654321, code loaded at reset; digit0 in [3:0], so the entry order is 1,2,3,4,5,6

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
prog_start  in  1  one-cycle pulse: begin or restart programming
abort  in  1  one-cycle pulse: cancel to IDLE; committed code untouched
digit_in  in  4  BCD digit, sampled when digit_valid=1
digit_valid  in  1  one-cycle strobe per digit
code_out  out  24  committed code; digit i at [4i+3:4i]
code_wr  out  1  one-cycle pulse on the edge code_out updates
status  out  3  0=IDLE 1=ENTER 2=CONFIRM 3=DONE 4=ERROR
digit_cnt  out  3  digits accepted in current pass, 0..5
hex0  out  7  active-low 7-seg of last accepted digit; 7'h7F blank

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, code_out=DEFAULT_CODE, code_wr=0, digit_cnt=0, hex0=7'h7F.
  - Entry and confirm buffers cleared; mismatch flag cleared.
  - Reset mid-entry discards both buffers.
- Input priority each cycle: abort > prog_start > digit_valid. A digit arriving in the same cycle as a higher-priority input is dropped.
- abort, from any state -> IDLE: buffers cleared, digit_cnt=0, hex0 blank. code_out holds.
- prog_start, from any state -> ENTER: digit_cnt=0, buffers and mismatch flag cleared, hex0 blank.
- IDLE: digit_valid ignored.
- ENTER:
  - On digit_valid with digit_in<=9: buf1[digit_cnt]<=digit_in, hex0<=seg(digit_in), digit_cnt+1.
  - On the 6th digit (digit_cnt==5): -> CONFIRM, digit_cnt<=0.
- CONFIRM:
  - On digit_valid with digit_in<=9: compare against buf1[digit_cnt]; set the sticky mismatch flag on inequality; hex0 updates; digit_cnt+1.
  - On the 6th digit, if no mismatch including this digit: -> DONE; on the same edge code_out<=buf1 and code_wr<=1 for exactly one cycle.
  - On the 6th digit with any mismatch: -> ERROR, code_out unchanged.
  - Mismatches are not reported early; all 6 digits are always consumed.
- Invalid digit (digit_in>=10, 4'hA..4'hF) in ENTER or CONFIRM: -> ERROR immediately, digit_cnt<=0, hex0 shows "E" (7'b0000110).
- DONE / ERROR: hold, ignore digit_valid, leave only on prog_start or abort.
- Latency: code_out and code_wr change on the clock edge that samples the final confirm digit; code_wr deasserts the next edge.
- digit_cnt never exceeds 5; it wraps to 0 on each pass transition.
- status is a registered decode of state: no glitches and no combinational path from inputs.

Decomposition:
- Package lock_pkg:
  - state enum {S_IDLE, S_ENTER, S_CONFIRM, S_DONE, S_ERROR} (3 bits), status encodings.
  - NUM_DIGITS and DIGIT_W constants.
  - 7-seg constants SEG_BLANK=7'h7F and SEG_E=7'b0000110, shared with the lock top.
- Sub-module seg7_bcd: combinational 4-bit -> active-low 7-seg, 0..9 only, blank otherwise. Reused by the lock display.

Test Plan:
- Reset with rst_n=0 mid-clock -> code_out=24'h654321, code_wr=0, status=0, hex0=7'h7F asynchronously, before any edge.
- prog_start, enter 9,8,7,6,5,4, confirm 9,8,7,6,5,4 -> status 1 then 2 then 3; code_out=24'h456789; code_wr high exactly one cycle; hex0=seg(4).
- Same entry, confirm 9,8,7,0,5,4 -> status=4 after the 6th confirm digit (not earlier); code_out remains 24'h654321; no code_wr.
- prog_start, digits 1,2, then digit_in=4'hB valid -> status=4, digit_cnt=0, hex0=7'b0000110; then prog_start -> status=1, digit_cnt=0.
- During CONFIRM after 3 digits assert abort and digit_valid together -> status=0, digit dropped, code_out unchanged; prog_start+digit_valid same cycle -> status=1, digit_cnt=0.
- After a successful commit, digit_valid pulses in DONE -> no change to code_out, digit_cnt or hex0; a second full program cycle with 1,1,1,1,1,1 -> code_out=24'h111111.
